// File: rtl/alu32_rr_sched.sv
// rtl/alu32_rr_sched.sv - round-robin scheduler sharing one 32-bit ALU between two requesters
module alu32_rr_sched #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_ci,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_ci,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_co,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic        alu_ci,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_out,
  input  logic        alu_co
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Settling counter counts down to zero; EXEC_CYCLES=1 gives a single EXEC cycle.
  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        ci_q, ci_d;
  logic        id_q, id_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_co_q, rsp_co_d;

  logic        grant_id;
  logic        accept;

  // Arbitration: a lone requester wins outright, contention is settled by prio.
  always_comb begin
    grant_id = (req0_valid & req1_valid) ? prio_q : req1_valid;
    accept   = (state_q == IDLE) & (req0_valid | req1_valid);
  end

  assign req0_ready = accept & ~grant_id;
  assign req1_ready = accept & grant_id;

  // Next-state logic: latch operands on accept, count the settling window, hold the response.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    ci_d       = ci_q;
    id_d       = id_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_co_d   = rsp_co_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = grant_id ? req1_op : req0_op;
          a_d     = grant_id ? req1_a  : req0_a;
          b_d     = grant_id ? req1_b  : req0_b;
          ci_d    = grant_id ? req1_ci : req0_ci;
          id_d    = grant_id;
          prio_d  = ~grant_id;
          cnt_d   = CNT_LOAD;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d = alu_out;
          rsp_co_d   = alu_co;
          rsp_id_d   = id_q;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      cnt_q      <= 4'd0;
      op_q       <= 3'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      ci_q       <= 1'b0;
      id_q       <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= 32'd0;
      rsp_co_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ci_q       <= ci_d;
      id_q       <= id_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_co_q   <= rsp_co_d;
    end
  end

  // Operands stay parked outside EXEC; the opcode is forced to 7 so the ALU idles at zero.
  assign alu_in1   = a_q;
  assign alu_in2   = b_q;
  assign alu_ci    = ci_q;
  assign alu_op    = (state_q == EXEC) ? op_q : 3'b111;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_co    = rsp_co_q;

endmodule

// File: tb/tb_alu32_rr_sched.sv
// tb/tb_alu32_rr_sched.sv - self-checking bench for alu32_rr_sched with randomized traffic
module tb_alu32_rr_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        v0[2], v1[2], rdy0[2], rdy1[2], ci0[2], ci1[2];
  logic [2:0]  op0[2], op1[2];
  logic [31:0] a0[2], a1[2], b0[2], b1[2];
  logic        rsp_valid[2], rsp_ready[2], rsp_id[2], rsp_co[2];
  logic [31:0] rsp_data[2];
  logic [31:0] alu_in1[2], alu_in2[2], alu_out[2];
  logic        alu_ci[2], alu_co[2];
  logic [2:0]  alu_op[2];

  int ecyc[2] = '{1, 3};
  int nvec = 0;
  int nerr = 0;

  // Behaviour of the shared gate-level ALU: {CO, FinalOut}.
  function automatic logic [32:0] alu_ref(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic ci);
    case (op)
      3'd0: return {1'b0, a & b};
      3'd1: return {1'b0, a | b};
      3'd2: return {1'b0, a ^ b};
      3'd3: return {1'b0, ~a};
      3'd4: return {1'b0, a} + {1'b0, b} + {32'd0, ci};
      3'd5: return {1'b0, a << 1};
      3'd6: return {1'b0, a >> 1};
      default: return 33'd0;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu32_rr_sched #(.EXEC_CYCLES(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0[g]), .req0_ready(rdy0[g]), .req0_op(op0[g]),
      .req0_a(a0[g]), .req0_b(b0[g]), .req0_ci(ci0[g]),
      .req1_valid(v1[g]), .req1_ready(rdy1[g]), .req1_op(op1[g]),
      .req1_a(a1[g]), .req1_b(b1[g]), .req1_ci(ci1[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_id(rsp_id[g]),
      .rsp_data(rsp_data[g]), .rsp_co(rsp_co[g]),
      .alu_in1(alu_in1[g]), .alu_in2(alu_in2[g]), .alu_ci(alu_ci[g]), .alu_op(alu_op[g]),
      .alu_out(alu_out[g]), .alu_co(alu_co[g])
    );
    assign {alu_co[g], alu_out[g]} = alu_ref(alu_op[g], alu_in1[g], alu_in2[g], alu_ci[g]);
  end

  task automatic drive_port(int d, int p, logic v, logic [2:0] op, logic [31:0] a, logic [31:0] b, logic ci);
    if (p == 0) begin
      v0[d] = v; op0[d] = op; a0[d] = a; b0[d] = b; ci0[d] = ci;
    end else begin
      v1[d] = v; op1[d] = op; a1[d] = a; b1[d] = b; ci1[d] = ci;
    end
  endtask

  task automatic clear_all();
    for (int d = 0; d < 2; d++) begin
      drive_port(d, 0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      drive_port(d, 1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      rsp_ready[d] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(int d, int p);
    bit ok = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if ((p == 0) ? rdy0[d] : rdy1[d]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL ready_timeout: dut %0d port %0d ready got 0 expected 1", d, p);
    end
  endtask

  // Let the acceptance edge pass, then withdraw the accepted request.
  task automatic accept_edge(int d, int p);
    @(negedge clk);
    if (p == 0) v0[d] = 1'b0; else v1[d] = 1'b0;
  endtask

  task automatic wait_rsp(int d, output int lat);
    lat = 0;
    while (!rsp_valid[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid[d]) begin
      nvec++;
      nerr++;
      $display("FAIL rsp_timeout: dut %0d rsp_valid got 0 expected 1", d);
    end
  endtask

  task automatic consume(int d);
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_all();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      nvec++;
      if ({rsp_valid[d], rsp_id[d], rsp_co[d], alu_ci[d], rdy0[d], rdy1[d]} !== 6'b0) begin
        nerr++;
        $display("FAIL reset_flags: dut %0d got %b expected 000000", d,
                 {rsp_valid[d], rsp_id[d], rsp_co[d], alu_ci[d], rdy0[d], rdy1[d]});
      end
      nvec++;
      if ({rsp_data[d], alu_in1[d], alu_in2[d]} !== 96'd0) begin
        nerr++;
        $display("FAIL reset_data: dut %0d got %h %h %h expected zeros", d, rsp_data[d], alu_in1[d], alu_in2[d]);
      end
      nvec++;
      if (alu_op[d] !== 3'b111) begin
        nerr++;
        $display("FAIL reset_alu_op: dut %0d got %0d expected 7", d, alu_op[d]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_carry();
    int lat;
    do_reset();
    drive_port(0, 0, 1'b1, 3'd4, 32'hFFFFFFFF, 32'h1, 1'b0);
    wait_ready(0, 0);
    accept_edge(0, 0);
    wait_rsp(0, lat);
    nvec++;
    if (lat !== 1) begin nerr++; $display("FAIL carry_latency: got %0d expected 1", lat); end
    nvec++;
    if ({rsp_id[0], rsp_co[0], rsp_data[0]} !== {1'b0, 1'b1, 32'h0}) begin
      nerr++;
      $display("FAIL carry_rsp: got id %0d co %0d data %h expected id 0 co 1 data 0", rsp_id[0], rsp_co[0], rsp_data[0]);
    end
    consume(0);
  endtask

  task automatic test_contention();
    int lat;
    do_reset();
    drive_port(0, 0, 1'b1, 3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    drive_port(0, 1, 1'b1, 3'd2, 32'h1, 32'h3, 1'b0);
    #1;
    nvec++;
    if ({rdy1[0], rdy0[0]} !== 2'b01) begin nerr++; $display("FAIL contention_grant0: got %b expected 01", {rdy1[0], rdy0[0]}); end
    accept_edge(0, 0);
    wait_rsp(0, lat);
    nvec++;
    if ({rsp_id[0], rsp_data[0]} !== {1'b0, 32'hF000F000}) begin
      nerr++;
      $display("FAIL contention_rsp0: got id %0d data %h expected id 0 data f000f000", rsp_id[0], rsp_data[0]);
    end
    consume(0);
    nvec++;
    if ({rdy1[0], rdy0[0]} !== 2'b10) begin nerr++; $display("FAIL contention_grant1: got %b expected 10", {rdy1[0], rdy0[0]}); end
    accept_edge(0, 1);
    wait_rsp(0, lat);
    nvec++;
    if ({rsp_id[0], rsp_data[0]} !== {1'b1, 32'h2}) begin
      nerr++;
      $display("FAIL contention_rsp1: got id %0d data %h expected id 1 data 2", rsp_id[0], rsp_data[0]);
    end
    consume(0);
  endtask

  task automatic test_backpressure();
    int lat;
    bit seen;
    logic [31:0] a = $urandom;
    logic [31:0] b = $urandom;
    logic [32:0] exp_r;
    do_reset();
    drive_port(0, 0, 1'b1, 3'd4, a, b, 1'b1);
    exp_r = alu_ref(3'd4, a, b, 1'b1);
    wait_ready(0, 0);
    accept_edge(0, 0);
    wait_rsp(0, lat);
    drive_port(0, 0, 1'b1, 3'd1, 32'h5, 32'h6, 1'b0);
    drive_port(0, 1, 1'b1, 3'd2, 32'h7, 32'h8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      nvec++;
      if ({rsp_valid[0], rsp_id[0], rsp_co[0], rsp_data[0], rdy0[0], rdy1[0]} !== {1'b1, 1'b0, exp_r, 2'b00}) begin
        nerr++;
        $display("FAIL bp_hold: cycle %0d got v %0d id %0d co %0d data %h rdy %0d%0d expected v 1 id 0 co %0d data %h rdy 00",
                 i, rsp_valid[0], rsp_id[0], rsp_co[0], rsp_data[0], rdy1[0], rdy0[0], exp_r[32], exp_r[31:0]);
      end
      @(negedge clk);
    end
    drive_port(0, 0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    drive_port(0, 1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    consume(0);
    seen = 1'b0;
    repeat (4) begin
      seen |= rsp_valid[0];
      @(negedge clk);
    end
    nvec++;
    if (seen !== 1'b0) begin nerr++; $display("FAIL bp_single_consume: rsp_valid got 1 expected 0 after consume"); end
  endtask

  task automatic test_settling();
    int lat = 0;
    int cnt = 0;
    do_reset();
    drive_port(1, 1, 1'b1, 3'd3, 32'h0000FFFF, $urandom, 1'b0);
    wait_ready(1, 1);
    accept_edge(1, 1);
    while (!rsp_valid[1] && lat < 40) begin
      if (alu_op[1] == 3'd3) cnt++;
      @(negedge clk);
      lat++;
    end
    nvec++;
    if (cnt !== 3 || lat !== 3) begin nerr++; $display("FAIL settle_window: got cnt %0d lat %0d expected 3 3", cnt, lat); end
    nvec++;
    if ({rsp_id[1], rsp_data[1]} !== {1'b1, 32'hFFFF0000}) begin
      nerr++;
      $display("FAIL settle_rsp: got id %0d data %h expected id 1 data ffff0000", rsp_id[1], rsp_data[1]);
    end
    nvec++;
    if ({alu_op[1], alu_in1[1]} !== {3'b111, 32'h0000FFFF}) begin
      nerr++;
      $display("FAIL settle_park: got op %0d in1 %h expected op 7 in1 0000ffff", alu_op[1], alu_in1[1]);
    end
    consume(1);
  endtask

  task automatic test_reset_mid_exec();
    bit seen = 1'b0;
    do_reset();
    drive_port(1, 0, 1'b1, 3'd4, $urandom, $urandom, 1'b1);
    wait_ready(1, 0);
    accept_edge(1, 0);
    nvec++;
    if (alu_op[1] !== 3'd4) begin nerr++; $display("FAIL midexec_op: got %0d expected 4", alu_op[1]); end
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({rsp_valid[1], alu_op[1]} !== {1'b0, 3'b111}) begin
      nerr++;
      $display("FAIL midexec_reset: got v %0d op %0d expected v 0 op 7", rsp_valid[1], alu_op[1]);
    end
    @(negedge clk);
    clear_all();
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      seen |= rsp_valid[1];
    end
    nvec++;
    if (seen !== 1'b0) begin nerr++; $display("FAIL midexec_no_rsp: rsp_valid got 1 expected 0"); end
    drive_port(1, 0, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
    drive_port(1, 1, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
    #1;
    nvec++;
    if ({rdy1[1], rdy0[1]} !== 2'b01) begin nerr++; $display("FAIL midexec_prio: got %b expected 01", {rdy1[1], rdy0[1]}); end
    clear_all();
  endtask

  task automatic test_op7();
    int lat;
    do_reset();
    drive_port(0, 1, 1'b1, 3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_ready(0, 1);
    accept_edge(0, 1);
    wait_rsp(0, lat);
    nvec++;
    if ({rsp_id[0], rsp_co[0], rsp_data[0]} !== {1'b1, 1'b0, 32'h0}) begin
      nerr++;
      $display("FAIL op7_rsp: got id %0d co %0d data %h expected id 1 co 0 data 0", rsp_id[0], rsp_co[0], rsp_data[0]);
    end
    consume(0);
  endtask

  // Random traffic: losers keep requesting; the model tracks the favoured port.
  task automatic test_random();
    bit          pend[2];
    logic [2:0]  pop[2];
    logic [31:0] pa[2], pb[2];
    logic        pci[2];
    bit          prio;
    int          g, lat;
    bit          rdy_seen;
    logic [32:0] exp_r;
    for (int d = 0; d < 2; d++) begin
      do_reset();
      prio = 1'b0;
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      for (int n = 0; n < 40; n++) begin
        for (int p = 0; p < 2; p++) begin
          if (!pend[p] && $urandom_range(0, 1) == 1) pend[p] = 1'b1;
        end
        if (!pend[0] && !pend[1]) pend[$urandom_range(0, 1)] = 1'b1;
        for (int p = 0; p < 2; p++) begin
          if (pend[p] && ((p == 0) ? !v0[d] : !v1[d])) begin
            pop[p] = 3'($urandom_range(0, 7));
            pa[p] = $urandom;
            pb[p] = $urandom;
            pci[p] = 1'($urandom_range(0, 1));
            drive_port(d, p, 1'b1, pop[p], pa[p], pb[p], pci[p]);
          end
        end
        #1;
        g = (pend[0] && pend[1]) ? int'(prio) : int'(pend[1]);
        nvec++;
        if ({rdy1[d], rdy0[d]} !== ((g == 1) ? 2'b10 : 2'b01)) begin
          nerr++;
          $display("FAIL rand_grant: dut %0d round %0d got %b expected port %0d", d, n, {rdy1[d], rdy0[d]}, g);
        end
        exp_r = alu_ref(pop[g], pa[g], pb[g], pci[g]);
        accept_edge(d, g);
        pend[g] = 1'b0;
        prio = (g == 0);
        wait_rsp(d, lat);
        nvec++;
        if (lat !== ecyc[d]) begin nerr++; $display("FAIL rand_latency: dut %0d got %0d expected %0d", d, lat, ecyc[d]); end
        nvec++;
        if ({rsp_id[d], rsp_co[d], rsp_data[d]} !== {g[0], exp_r}) begin
          nerr++;
          $display("FAIL rand_rsp: dut %0d round %0d got id %0d co %0d data %h expected id %0d co %0d data %h",
                   d, n, rsp_id[d], rsp_co[d], rsp_data[d], g, exp_r[32], exp_r[31:0]);
        end
        rdy_seen = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          rdy_seen |= rdy0[d] | rdy1[d];
        end
        nvec++;
        if (rdy_seen !== 1'b0) begin nerr++; $display("FAIL rand_resp_ready: dut %0d ready got 1 expected 0 in RESP", d); end
        consume(d);
      end
      clear_all();
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_contention();
    test_backpressure();
    test_settling();
    test_reset_mid_exec();
    test_op7();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
